// File: rtl/btn_toggle_conditioner_pkg.sv
// Shared state encodings for the push-button toggle conditioner.
package btn_toggle_conditioner_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle  = 2'd0,
        StArmHi = 2'd1,
        StHeld  = 2'd2,
        StArmLo = 2'd3
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous board inputs; synchronous active-low clear.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/btn_toggle_conditioner.sv
// Synchronises and debounces a raw push-button, emitting one t_pulse per clean press.
module btn_toggle_conditioner
    import btn_toggle_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    output logic       t_pulse,
    output logic       btn_level,
    output logic [1:0] state_dbg
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_sync;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             t_pulse_q, t_pulse_d;
    logic             btn_level_q, btn_level_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_raw),
        .q_o   (btn_sync)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        t_pulse_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (btn_sync) begin
                    state_d = StArmHi;
                    cnt_d   = '0;
                end
            end
            StArmHi: begin
                if (!btn_sync) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d   = StHeld;
                    cnt_d     = '0;
                    t_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHeld: begin
                if (!btn_sync) begin
                    state_d = StArmLo;
                    cnt_d   = '0;
                end
            end
            StArmLo: begin
                // A bounce back high returns to HELD silently: only ARM_HI may pulse.
                if (btn_sync) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        btn_level_d = (state_d == StHeld) || (state_d == StArmLo);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            t_pulse_q   <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_pulse_q   <= t_pulse_d;
            btn_level_q <= btn_level_d;
        end
    end

    assign t_pulse   = t_pulse_q;
    assign btn_level = btn_level_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_btn_toggle_conditioner.sv
// Directed bench: one instance with DEBOUNCE_CYCLES=4, one with DEBOUNCE_CYCLES=1.
module tb_btn_toggle_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_a, btn_b;
    logic       t_pulse_a, t_pulse_b;
    logic       level_a, level_b;
    logic [1:0] st_a, st_b;

    int tests = 0;
    int fails = 0;
    int pa = 0;
    int pb = 0;
    logic tq = 1'b0;
    int base;

    always #5 clk = ~clk;

    btn_toggle_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_a),
        .t_pulse   (t_pulse_a),
        .btn_level (level_a),
        .state_dbg (st_a)
    );

    btn_toggle_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_b),
        .t_pulse   (t_pulse_b),
        .btn_level (level_b),
        .state_dbg (st_b)
    );

    // Pulse counters and a model of the downstream toggle flip-flop.
    always @(posedge clk) begin
        if (t_pulse_a) pa <= pa + 1;
        if (t_pulse_b) pb <= pb + 1;
        if (!rst_n) tq <= 1'b0;
        else if (t_pulse_a) tq <= ~tq;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with button asserted: must still clear everything.
        rst_n = 1'b0; btn_a = 1'b1; btn_b = 1'b1;
        tick(3);
        check("rst_t_pulse", 32'(t_pulse_a), 0);
        check("rst_level",   32'(level_a), 0);
        check("rst_state",   32'(st_a), 0);
        btn_a = 1'b0; btn_b = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("idle_state", 32'(st_a), 0);

        // Clean press, D=4: pulse after edge 7.
        base = pa;
        btn_a = 1'b1;
        tick(6);
        check("press_e6_pulse", 32'(t_pulse_a), 0);
        check("press_e6_state", 32'(st_a), 1);
        check("press_e6_level", 32'(level_a), 0);
        tick(1);
        check("press_e7_pulse", 32'(t_pulse_a), 1);
        check("press_e7_level", 32'(level_a), 1);
        check("press_e7_state", 32'(st_a), 2);
        tick(1);
        check("press_e8_pulse", 32'(t_pulse_a), 0);
        tick(12);
        check("hold_one_pulse", 32'(pa - base), 1);
        check("hold_state",     32'(st_a), 2);

        // Clean release: level falls after edge 7.
        btn_a = 1'b0;
        tick(6);
        check("rel_e6_level", 32'(level_a), 1);
        check("rel_e6_state", 32'(st_a), 3);
        tick(1);
        check("rel_e7_level", 32'(level_a), 0);
        check("rel_e7_state", 32'(st_a), 0);

        // Bouncy press 1,0,1,1,0 then stable 1 from edge 6; pulse after edge 12.
        base = pa;
        btn_a = 1'b1; tick(1);
        btn_a = 1'b0; tick(1);
        btn_a = 1'b1; tick(1);
        check("bnc_e3_state", 32'(st_a), 1);
        btn_a = 1'b1; tick(1);
        check("bnc_e4_state", 32'(st_a), 0);
        btn_a = 1'b0; tick(1);
        btn_a = 1'b1;
        tick(6);
        check("bnc_e11_pulse", 32'(t_pulse_a), 0);
        check("bnc_e11_count", 32'(pa - base), 0);
        check("bnc_e11_state", 32'(st_a), 1);
        tick(1);
        check("bnc_e12_pulse", 32'(t_pulse_a), 1);
        tick(3);
        check("bnc_one_pulse", 32'(pa - base), 1);

        // Release bounce 0,1,0 then stable 0: final fall at edge 3, IDLE after edge 9.
        base = pa;
        btn_a = 1'b0; tick(1);
        btn_a = 1'b1; tick(1);
        btn_a = 1'b0; tick(1);
        check("rb_e3_state", 32'(st_a), 3);
        tick(1);
        check("rb_e4_state", 32'(st_a), 2);
        check("rb_e4_level", 32'(level_a), 1);
        tick(4);
        check("rb_e8_level", 32'(level_a), 1);
        check("rb_e8_state", 32'(st_a), 3);
        tick(1);
        check("rb_e9_level", 32'(level_a), 0);
        check("rb_e9_state", 32'(st_a), 0);
        check("rb_no_pulse", 32'(pa - base), 0);

        // Reset mid-debounce in ARM_HI with cnt=2, button still held.
        btn_a = 1'b1;
        tick(5);
        check("mr_e5_state", 32'(st_a), 1);
        rst_n = 1'b0;
        tick(1);
        check("mr_rst_pulse", 32'(t_pulse_a), 0);
        check("mr_rst_level", 32'(level_a), 0);
        check("mr_rst_state", 32'(st_a), 0);
        rst_n = 1'b1;
        base = pa;
        tick(6);
        check("mr_e6_pulse", 32'(t_pulse_a), 0);
        tick(1);
        check("mr_e7_pulse", 32'(t_pulse_a), 1);
        check("mr_e7_state", 32'(st_a), 2);
        btn_a = 1'b0;
        tick(10);
        check("mr_one_pulse", 32'(pa - base), 1);

        // Three press/release cycles from reset: three pulses, toggle output ends at 1.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        base = pa;
        for (int i = 0; i < 3; i++) begin
            btn_a = 1'b1; tick(15);
            btn_a = 1'b0; tick(15);
        end
        check("cyc3_pulses", 32'(pa - base), 3);
        check("cyc3_toggle", 32'(tq), 1);
        check("cyc3_state",  32'(st_a), 0);

        // D=1: pulse after edge 4; ARM states last one cycle.
        check("d1_idle", 32'(st_b), 0);
        base = pb;
        btn_b = 1'b1;
        tick(3);
        check("d1_e3_state", 32'(st_b), 1);
        check("d1_e3_pulse", 32'(t_pulse_b), 0);
        tick(1);
        check("d1_e4_pulse", 32'(t_pulse_b), 1);
        check("d1_e4_level", 32'(level_b), 1);
        check("d1_e4_state", 32'(st_b), 2);
        tick(1);
        check("d1_e5_pulse", 32'(t_pulse_b), 0);
        btn_b = 1'b0;
        tick(3);
        check("d1_rel_e3_state", 32'(st_b), 3);
        tick(1);
        check("d1_rel_e4_state", 32'(st_b), 0);
        check("d1_rel_e4_level", 32'(level_b), 0);

        // D=1 single-cycle glitch: enters ARM_HI then aborts, no pulse.
        btn_b = 1'b1; tick(1);
        btn_b = 1'b0;
        tick(2);
        check("gl_e3_state", 32'(st_b), 1);
        tick(1);
        check("gl_e4_state", 32'(st_b), 0);
        tick(5);
        check("gl_no_pulse", 32'(pb - base), 1);
        check("gl_level",    32'(level_b), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
